fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Fetch stage directly downstream of the PC register; it also drives that register's next-value input.
- Takes the current PC and issues instruction-memory reads through a valid/ready handshake.
- Buffers in-order responses, with their PCs, in a DEPTH-entry queue feeding decode.
- Computes PCNext: hold the PC, advance it by 4, or take a redirect target. Also flushes wrong-path fetches on redirect.

Parameters:
- D_WIDTH, 32, width of PC, address and instruction.
- DEPTH, 4, queue entries (power of 2, ≥2); also the maximum number of outstanding plus buffered fetches.
- RESET_VECTOR, 32'hBFC00000, PCNext value while reset is held.

Ports:
- CLK  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- PC  input  D_WIDTH  current PC from the PC register.
- PCNext  output  D_WIDTH  next PC, to the PC register.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  D_WIDTH  fetch address.
- imem_rsp_valid  input  1  response valid; in order, one per accepted request, no backpressure.
- imem_rsp_data  input  D_WIDTH  fetched instruction.
- redirect_valid  input  1  branch/jump redirect from execute.
- redirect_target  input  D_WIDTH  redirect PC.
- dec_valid  output  1  head entry valid.
- dec_ready  input  1  decode accepts head.
- dec_instr  output  D_WIDTH  head instruction.
- dec_pc  output  D_WIDTH  PC of head instruction.

Behaviour:
- Reset (async assert, sync release):
  - All pointers and counters clear; every entry becomes invalid.
  - dec_valid=0, imem_req_valid=0, dec_instr=0, dec_pc=0.
  - PCNext=RESET_VECTOR while rst is high.
  - Any in-flight memory responses are forgotten; the memory is reset with this block.
- Queue structure: three pointers.
  - Alloc pointer: a slot is reserved and its PC stored on each request fire (imem_req_valid & imem_req_ready).
  - Fill pointer: imem_rsp_data is written to the oldest reserved, unfilled slot on each response; the slot is marked filled.
  - Head pointer: advances on each pop (dec_valid & dec_ready).
- Pointer width is log2(DEPTH)+1, so full and empty are distinguishable.
- Credit rule:
  - imem_req_valid = !redirect_valid & ((reserved_count + drop_count) < DEPTH).
  - reserved_count counts allocated-not-popped slots, filled or not.
- imem_req_addr = {PC[D_WIDTH-1:2], 2'b00}; PC[1:0] is ignored.
- PCNext priority:
  - redirect_valid → redirect_target.
  - Else request fire → PC+4, mod 2^D_WIDTH; 32'hFFFFFFFC wraps to 0.
  - Else → PC (stall).
- Decode outputs:
  - dec_valid = head slot filled. Purely from state, never combinational from inputs.
  - dec_instr and dec_pc come from the head slot.
  - Minimum latency: response in cycle N → dec_valid in cycle N+1.
- Full queue: imem_req_valid=0 and PCNext=PC until a pop frees a credit. A pop in cycle N allows a request in cycle N+1.
- Pop and response in the same cycle are both honoured.
- Redirect handling:
  - Redirect in cycle N: at the edge, all slots are invalidated and the pointers reset to equal values.
  - drop_count becomes the count of requested-but-unanswered slots, minus 1 if imem_rsp_valid is high in cycle N.
  - Later responses decrement drop_count and are discarded while drop_count>0.
  - A pop handshake in cycle N is accepted, but the flush overrides it.
  - Requests resume in cycle N+1 at the redirect target, subject to the credit rule.
- Back-to-back redirects: the later target wins, and drop accounting accumulates correctly.
- Protocol violation: a response with nothing outstanding and drop_count=0 is ignored. Simulation-only assertion fires.

Optional Feature:
- Macro: FETCH_QUEUE_PERF_EN.
- When defined, two outputs are added, both reset to 0 and saturating at all-ones:
  - perf_stall_cnt [31:0]: counts cycles with imem_req_valid=0 and redirect_valid=0.
  - perf_flush_cnt [31:0]: counts discarded responses.
- When undefined, neither port nor logic exists; behaviour is otherwise identical.

Test Plan:
- Reset: assert rst mid-stream with 3 entries buffered → immediately dec_valid=0, imem_req_valid=0, PCNext=32'hBFC00000. After release with PC=BFC00000 and ready=1 → addr BFC00000, PCNext BFC00004.
- Streaming: ready=1, 1-cycle response, dec_ready=1 → dec_pc sequence BFC00000, BFC00004, BFC00008, ... one per cycle, with dec_instr matching the memory image.
- Full queue: dec_ready=0, DEPTH=4 → exactly 4 requests accepted, then imem_req_valid=0 and PCNext=PC. One pop → one new request in the next cycle.
- Redirect with 2 outstanding: redirect_valid with target 0x80 → PCNext=0x80 and both old responses discarded (perf_flush_cnt=2 if enabled). First dec_pc after redirect is 0x80.
- Redirect in the same cycle as a response and a pop → drop_count=outstanding-1, no wrong-path entry reaches decode, and the request in the next cycle has addr=target.
- Wrap and misalignment: PC=32'hFFFFFFFC fire → PCNext=0. PC=0x102 → imem_req_addr=0x100.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: fetch stage between the PC register and decode.
// Issues instruction-memory reads for the current PC, buffers in-order
// responses with their PCs in a DEPTH-entry queue, computes PCNext, and
// flushes wrong-path fetches on a redirect.
// Optional build macro FETCH_QUEUE_PERF_EN adds perf_stall_cnt/perf_flush_cnt.
//
// Handshakes: a transfer happens on a rising CLK edge when valid and ready are
// both high in that cycle; valid never depends on the ready it is paired with.
// imem_rsp_valid has no ready: every response is consumed the cycle it appears.
module fetch_queue #(
    parameter int                 D_WIDTH      = 32,
    parameter int                 DEPTH        = 4,
    parameter logic [D_WIDTH-1:0] RESET_VECTOR = D_WIDTH'(32'hBFC00000)
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] PC,
    output logic [D_WIDTH-1:0] PCNext,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [D_WIDTH-1:0] imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [D_WIDTH-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [D_WIDTH-1:0] redirect_target,
`ifdef FETCH_QUEUE_PERF_EN
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt,
`endif
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [D_WIDTH-1:0] dec_instr,
    output logic [D_WIDTH-1:0] dec_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Pointers carry one extra wrap bit so that full and empty differ.
    logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [PW-1:0] fill_ptr_q,  fill_ptr_d;
    logic [PW-1:0] head_ptr_q,  head_ptr_d;
    // Responses still owed by memory for fetches thrown away by a redirect.
    logic [PW-1:0] drop_cnt_q,  drop_cnt_d;

    logic [DEPTH-1:0]   slot_filled_q, slot_filled_d;
    logic [D_WIDTH-1:0] slot_pc_q    [DEPTH];
    logic [D_WIDTH-1:0] slot_instr_q [DEPTH];

    logic [AW-1:0] alloc_idx, fill_idx, head_idx;
    logic [PW-1:0] reserved_cnt;
    logic [PW-1:0] outstanding_cnt;
    logic [PW-1:0] credit_used;
    logic [PW-1:0] unanswered;
    logic          req_fire;
    logic          rsp_write;
    logic          rsp_discard;
    logic          pop;

    assign alloc_idx = alloc_ptr_q[AW-1:0];
    assign fill_idx  = fill_ptr_q[AW-1:0];
    assign head_idx  = head_ptr_q[AW-1:0];

    // Reserved = allocated and not yet popped; outstanding = allocated and not
    // yet answered. Both are bounded by DEPTH, as is their sum with drop_cnt.
    assign reserved_cnt    = alloc_ptr_q - head_ptr_q;
    assign outstanding_cnt = alloc_ptr_q - fill_ptr_q;
    assign credit_used     = reserved_cnt + drop_cnt_q;
    assign unanswered      = drop_cnt_q + outstanding_cnt;

    assign imem_req_valid = !rst && !redirect_valid && (credit_used < PW'(DEPTH));
    assign imem_req_addr  = {PC[D_WIDTH-1:2], 2'b00};
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response lands in the queue only when nothing is owed to a flush.
    assign rsp_write   = imem_rsp_valid && !redirect_valid &&
                         (drop_cnt_q == '0) && (outstanding_cnt != '0);
    assign rsp_discard = imem_rsp_valid &&
                         ((drop_cnt_q != '0) || (redirect_valid && (outstanding_cnt != '0)));

    assign dec_valid = slot_filled_q[head_idx];
    assign dec_instr = slot_instr_q[head_idx];
    assign dec_pc    = slot_pc_q[head_idx];
    assign pop       = dec_valid && dec_ready;

    // Next PC: redirect beats sequential advance, which beats a stall.
    always_comb begin
        PCNext = PC;
        if (rst) begin
            PCNext = RESET_VECTOR;
        end else if (redirect_valid) begin
            PCNext = redirect_target;
        end else if (req_fire) begin
            PCNext = PC + D_WIDTH'(4);
        end
    end

    // Pointer, fill-flag and drop-count updates; a redirect overrides everything.
    always_comb begin
        alloc_ptr_d   = alloc_ptr_q;
        fill_ptr_d    = fill_ptr_q;
        head_ptr_d    = head_ptr_q;
        drop_cnt_d    = drop_cnt_q;
        slot_filled_d = slot_filled_q;
        if (redirect_valid) begin
            alloc_ptr_d   = '0;
            fill_ptr_d    = '0;
            head_ptr_d    = '0;
            slot_filled_d = '0;
            if (imem_rsp_valid && (unanswered != '0)) begin
                drop_cnt_d = unanswered - PW'(1);
            end else begin
                drop_cnt_d = unanswered;
            end
        end else begin
            if (req_fire) begin
                alloc_ptr_d = alloc_ptr_q + PW'(1);
            end
            if (rsp_write) begin
                fill_ptr_d              = fill_ptr_q + PW'(1);
                slot_filled_d[fill_idx] = 1'b1;
            end
            if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - PW'(1);
            end
            if (pop) begin
                head_ptr_d              = head_ptr_q + PW'(1);
                slot_filled_d[head_idx] = 1'b0;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            alloc_ptr_q   <= '0;
            fill_ptr_q    <= '0;
            head_ptr_q    <= '0;
            drop_cnt_q    <= '0;
            slot_filled_q <= '0;
        end else begin
            alloc_ptr_q   <= alloc_ptr_d;
            fill_ptr_q    <= fill_ptr_d;
            head_ptr_q    <= head_ptr_d;
            drop_cnt_q    <= drop_cnt_d;
            slot_filled_q <= slot_filled_d;
        end
    end

    // Slot payload: PC captured at request, instruction captured at response.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_pc_q[i]    <= '0;
                slot_instr_q[i] <= '0;
            end
        end else begin
            if (req_fire) begin
                slot_pc_q[alloc_idx] <= PC;
            end
            if (rsp_write) begin
                slot_instr_q[fill_idx] <= imem_rsp_data;
            end
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    // Saturating counters for stall cycles and discarded responses.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (!imem_req_valid && !redirect_valid && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (rsp_discard && (perf_flush_q != '1)) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    logic unused_discard;
    assign unused_discard = rsp_discard;
`endif

    // A response with nothing requested and nothing owed breaks the memory contract.
    assert property (@(posedge CLK) disable iff (rst)
        !(imem_rsp_valid && (drop_cnt_q == '0) && (outstanding_cnt == '0)));

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: closed-loop bench for fetch_queue. The bench owns the PC
// register and an in-order instruction memory with random latency. A queue
// model of reserved fetches and owed drops predicts every output each cycle.
module tb_fetch_queue;

    localparam int          DW    = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'hBFC00000;

    logic          CLK;
    logic          rst;
    logic [DW-1:0] PC;
    logic [DW-1:0] PCNext;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [DW-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [DW-1:0] imem_rsp_data;
    logic          redirect_valid;
    logic [DW-1:0] redirect_target;
    logic          dec_valid;
    logic          dec_ready;
    logic [DW-1:0] dec_instr;
    logic [DW-1:0] dec_pc;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0]   perf_stall_cnt;
    logic [31:0]   perf_flush_cnt;
`endif

    fetch_queue #(.D_WIDTH(DW), .DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
        .CLK             (CLK),
        .rst             (rst),
        .PC              (PC),
        .PCNext          (PCNext),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
`ifdef FETCH_QUEUE_PERF_EN
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_flush_cnt  (perf_flush_cnt),
`endif
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_instr       (dec_instr),
        .dec_pc          (dec_pc)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Reference model: reserved entries in fetch order, plus owed drops.
    logic [DW-1:0] exp_q[$];
    bit            exp_filled_q[$];
    int            m_drop;

    // Memory: accepted request addresses and the cycle each may answer.
    logic [DW-1:0] mem_addr_q[$];
    int            mem_due_q[$];
    bit            mem_hold;
    int            lat_min;
    int            lat_max;

    logic [DW-1:0] popped_q[$];
    bit            last_fire;
    logic [DW-1:0] last_addr;
    logic [DW-1:0] last_pcnext;
    logic [DW-1:0] last_pc;

    function automatic logic [DW-1:0] mem_word(input logic [DW-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [DW-1:0] align(input logic [DW-1:0] a);
        return {a[DW-1:2], 2'b00};
    endfunction

    task automatic do_reset();
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        dec_ready       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = '0;
        PC              = RV;
        exp_q.delete();
        exp_filled_q.delete();
        m_drop = 0;
        mem_addr_q.delete();
        mem_due_q.delete();
        popped_q.delete();
        mem_hold = 1'b0;
        lat_min  = 1;
        lat_max  = 1;
        repeat (2) @(negedge CLK);
        rst = 1'b0;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input bit rdy, input bit drdy, input bit rv, input logic [DW-1:0] rt);
        bit            m_req;
        bit            m_dv;
        bit            m_fire;
        bit            rsp;
        bit            found;
        int            unans;
        logic [DW-1:0] exp_next;
        imem_req_ready  = rdy;
        dec_ready       = drdy;
        redirect_valid  = rv;
        redirect_target = rt;
        rsp = !mem_hold && (mem_addr_q.size() > 0) && (mem_due_q[0] <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(mem_addr_q[0]) : $urandom();
        #1;
        m_req    = !rv && ((exp_q.size() + m_drop) < DEPTH);
        m_dv     = (exp_q.size() > 0) && exp_filled_q[0];
        m_fire   = m_req && rdy;
        exp_next = rv ? rt : (m_fire ? PC + 32'd4 : PC);

        tests_run++;
        if (imem_req_valid !== m_req) begin
            tests_failed++;
            $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, m_req);
        end
        tests_run++;
        if (imem_req_addr !== align(PC)) begin
            tests_failed++;
            $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, align(PC));
        end
        tests_run++;
        if (PCNext !== exp_next) begin
            tests_failed++;
            $display("FAIL pcnext cyc=%0d got=%h exp=%h", cyc, PCNext, exp_next);
        end
        tests_run++;
        if (dec_valid !== m_dv) begin
            tests_failed++;
            $display("FAIL dec_valid cyc=%0d got=%b exp=%b", cyc, dec_valid, m_dv);
        end
        if (m_dv) begin
            tests_run++;
            if (dec_pc !== exp_q[0]) begin
                tests_failed++;
                $display("FAIL dec_pc cyc=%0d got=%h exp=%h", cyc, dec_pc, exp_q[0]);
            end
            tests_run++;
            if (dec_instr !== mem_word(align(exp_q[0]))) begin
                tests_failed++;
                $display("FAIL dec_instr cyc=%0d got=%h exp=%h", cyc, dec_instr, mem_word(align(exp_q[0])));
            end
        end

        last_fire   = imem_req_valid && imem_req_ready;
        last_addr   = imem_req_addr;
        last_pcnext = PCNext;
        last_pc     = PC;
        if (dec_valid && dec_ready) popped_q.push_back(dec_pc);

        @(posedge CLK);
        #1;
        // Memory answers what the DUT actually requested, in order.
        if (rsp) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
        if (last_fire) begin
            mem_addr_q.push_back(last_addr);
            mem_due_q.push_back(cyc + $urandom_range(lat_min, lat_max));
        end
        // Model update from the rules of the fetch stage.
        if (rv) begin
            unans = m_drop;
            foreach (exp_filled_q[i]) if (!exp_filled_q[i]) unans++;
            if (rsp && unans > 0) unans--;
            m_drop = unans;
            exp_q.delete();
            exp_filled_q.delete();
        end else begin
            if (rsp) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    found = 1'b0;
                    for (int i = 0; i < exp_filled_q.size(); i++) begin
                        if (!found && !exp_filled_q[i]) begin
                            exp_filled_q[i] = 1'b1;
                            found = 1'b1;
                        end
                    end
                end
            end
            if (m_dv && drdy) begin
                void'(exp_q.pop_front());
                void'(exp_filled_q.pop_front());
            end
            if (m_fire) begin
                exp_q.push_back(last_pc);
                exp_filled_q.push_back(1'b0);
            end
        end
        PC = last_pcnext;
        cyc++;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_req_ready = 1'b0; dec_ready = 1'b0; redirect_valid = 1'b0;
        redirect_target = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; PC = RV;
        @(negedge CLK);
        #1;
        tests_run++;
        if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valids got dv=%b rv=%b exp 0 0", dec_valid, imem_req_valid);
        end
        tests_run++;
        if (PCNext !== RV) begin
            tests_failed++;
            $display("FAIL reset_pcnext got=%h exp=%h", PCNext, RV);
        end
        tests_run++;
        if (dec_instr !== '0 || dec_pc !== '0) begin
            tests_failed++;
            $display("FAIL reset_dec_data got instr=%h pc=%h exp 0 0", dec_instr, dec_pc);
        end
        do_reset();
        repeat (4) cycle(1'b1, 1'b0, 1'b0, '0);
        tests_run++;
        if (exp_q.size() < 3) begin
            tests_failed++;
            $display("FAIL reset_prefill got=%0d exp>=3", exp_q.size());
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0 || PCNext !== RV) begin
            tests_failed++;
            $display("FAIL reset_async got dv=%b rv=%b pcn=%h exp 0 0 %h",
                     dec_valid, imem_req_valid, PCNext, RV);
        end
        @(negedge CLK);
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, '0);
        tests_run++;
        if (!last_fire || last_addr !== RV || last_pcnext !== RV + 32'd4) begin
            tests_failed++;
            $display("FAIL reset_first_fetch got fire=%b addr=%h pcn=%h exp 1 %h %h",
                     last_fire, last_addr, last_pcnext, RV, RV + 32'd4);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        repeat (20) cycle(1'b1, 1'b1, 1'b0, '0);
        tests_run++;
        if (popped_q.size() != 18) begin
            tests_failed++;
            $display("FAIL stream_count got=%0d exp=18", popped_q.size());
        end
        foreach (popped_q[k]) begin
            tests_run++;
            if (popped_q[k] !== RV + 32'(4 * k)) begin
                tests_failed++;
                $display("FAIL stream_pc k=%0d got=%h exp=%h", k, popped_q[k], RV + 32'(4 * k));
            end
        end
    endtask

    task automatic test_full();
        int fires;
        do_reset();
        fires = 0;
        repeat (8) begin
            cycle(1'b1, 1'b0, 1'b0, '0);
            if (last_fire) fires++;
        end
        tests_run++;
        if (fires != DEPTH) begin
            tests_failed++;
            $display("FAIL full_fires got=%0d exp=%0d", fires, DEPTH);
        end
        tests_run++;
        if (last_fire || last_pcnext !== last_pc) begin
            tests_failed++;
            $display("FAIL full_stall got fire=%b pcn=%h exp 0 %h", last_fire, last_pcnext, last_pc);
        end
        cycle(1'b1, 1'b1, 1'b0, '0);
        tests_run++;
        if (last_fire) begin
            tests_failed++;
            $display("FAIL full_pop_cycle got fire=1 exp=0");
        end
        cycle(1'b1, 1'b0, 1'b0, '0);
        tests_run++;
        if (!last_fire) begin
            tests_failed++;
            $display("FAIL full_after_pop got fire=0 exp=1");
        end
        cycle(1'b1, 1'b0, 1'b0, '0);
        tests_run++;
        if (last_fire) begin
            tests_failed++;
            $display("FAIL full_one_only got fire=1 exp=0");
        end
    endtask

    task automatic test_redirect();
`ifdef FETCH_QUEUE_PERF_EN
        logic [31:0] flush0;
`endif
        do_reset();
        mem_hold = 1'b1;
        repeat (2) cycle(1'b1, 1'b0, 1'b0, '0);
`ifdef FETCH_QUEUE_PERF_EN
        flush0 = perf_flush_cnt;
`endif
        cycle(1'b1, 1'b0, 1'b1, 32'h80);
        tests_run++;
        if (last_pcnext !== 32'h80 || last_fire) begin
            tests_failed++;
            $display("FAIL redir_pcnext got pcn=%h fire=%b exp 00000080 0", last_pcnext, last_fire);
        end
        popped_q.delete();
        mem_hold = 1'b0;
        repeat (12) cycle(1'b1, 1'b1, 1'b0, '0);
        tests_run++;
        if (popped_q.size() == 0 || popped_q[0] !== 32'h80) begin
            tests_failed++;
            $display("FAIL redir_first_pc got n=%0d pc=%h exp 00000080", popped_q.size(),
                     (popped_q.size() > 0) ? popped_q[0] : 32'hx);
        end
`ifdef FETCH_QUEUE_PERF_EN
        tests_run++;
        if (perf_flush_cnt - flush0 !== 32'd2) begin
            tests_failed++;
            $display("FAIL redir_flush_cnt got=%0d exp=2", perf_flush_cnt - flush0);
        end
`endif
    endtask

    task automatic test_redirect_rsp_pop();
        int fires;
        do_reset();
        repeat (2) cycle(1'b1, 1'b0, 1'b0, '0);
        mem_hold = 1'b1;
        repeat (2) cycle(1'b1, 1'b0, 1'b0, '0);
        mem_hold = 1'b0;
        cycle(1'b1, 1'b1, 1'b1, 32'h1000);
        popped_q.delete();
        mem_hold = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, '0);
        tests_run++;
        if (!last_fire || last_addr !== 32'h1000) begin
            tests_failed++;
            $display("FAIL rsp_pop_next_req got fire=%b addr=%h exp 1 00001000", last_fire, last_addr);
        end
        fires = 1;
        repeat (4) begin
            cycle(1'b1, 1'b1, 1'b0, '0);
            if (last_fire) fires++;
        end
        tests_run++;
        if (fires != DEPTH - 2) begin
            tests_failed++;
            $display("FAIL rsp_pop_credits got=%0d exp=%0d", fires, DEPTH - 2);
        end
        mem_hold = 1'b0;
        repeat (15) cycle(1'b1, 1'b1, 1'b0, '0);
        tests_run++;
        if (popped_q.size() == 0) begin
            tests_failed++;
            $display("FAIL rsp_pop_none got=0 exp>0");
        end
        foreach (popped_q[k]) begin
            tests_run++;
            if (popped_q[k] !== 32'h1000 + 32'(4 * k)) begin
                tests_failed++;
                $display("FAIL rsp_pop_path k=%0d got=%h exp=%h", k, popped_q[k], 32'h1000 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem_hold = 1'b1;
        repeat (3) cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b1, 32'h200);
        cycle(1'b1, 1'b0, 1'b1, 32'h300);
        tests_run++;
        if (last_pcnext !== 32'h300) begin
            tests_failed++;
            $display("FAIL b2b_pcnext got=%h exp=00000300", last_pcnext);
        end
        popped_q.delete();
        mem_hold = 1'b0;
        repeat (15) cycle(1'b1, 1'b1, 1'b0, '0);
        tests_run++;
        if (popped_q.size() < 2 || popped_q[0] !== 32'h300 || popped_q[1] !== 32'h304) begin
            tests_failed++;
            $display("FAIL b2b_path got n=%0d exp first 00000300 00000304", popped_q.size());
        end
    endtask

    task automatic test_wrap_misalign();
        do_reset();
        PC = 32'hFFFFFFFC;
        cycle(1'b1, 1'b1, 1'b0, '0);
        tests_run++;
        if (!last_fire || last_pcnext !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap got fire=%b pcn=%h exp 1 00000000", last_fire, last_pcnext);
        end
        PC = 32'h102;
        cycle(1'b1, 1'b1, 1'b0, '0);
        tests_run++;
        if (last_addr !== 32'h100 || last_pcnext !== 32'h106) begin
            tests_failed++;
            $display("FAIL misalign got addr=%h pcn=%h exp 00000100 00000106", last_addr, last_pcnext);
        end
        repeat (6) cycle(1'b1, 1'b1, 1'b0, '0);
    endtask

    task automatic test_random();
        logic [DW-1:0] tgt;
        do_reset();
        lat_min = 1;
        lat_max = 4;
        repeat (1500) begin
            tgt = $urandom() & 32'hFFFFFFFC;
            if ($urandom_range(0, 7) == 0) tgt = tgt | 32'h2;
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 19) == 0, tgt);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_full();
        test_redirect();
        test_redirect_rsp_pop();
        test_back_to_back();
        test_wrap_misalign();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
